// File: rtl/vsynth_voice_pkg.sv
// rtl/vsynth_voice_pkg.sv - shared types and constants for the wavetable voice engine
package vsynth_voice_pkg;
    localparam int SAMPLE_W = 8;
    localparam int NOTE_W   = 7;
    localparam int STEP_W   = 16;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [6:0]        prog;
        logic              gate;
    } voice_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;
endpackage

// File: rtl/sample_rom.sv
// rtl/sample_rom.sv - program/phase to 8-bit sample, one-cycle registered read
module sample_rom
    import vsynth_voice_pkg::*;
#(
    parameter int PHASE_W = 7
) (
    input  logic                clk_i,
    input  logic                ce_i,
    input  logic [6:0]          a1_i,
    input  logic [PHASE_W-1:0]  a2_i,
    output logic [SAMPLE_W-1:0] data_o
);
    logic [SAMPLE_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (ce_i) data_q <= SAMPLE_W'({a2_i, 1'b0}) + SAMPLE_W'(a1_i);
    end

    assign data_o = data_q;
endmodule

// File: rtl/step_size_rom.sv
// rtl/step_size_rom.sv - note number to phase step, one-cycle registered read
module step_size_rom
    import vsynth_voice_pkg::*;
(
    input  logic              clk_i,
    input  logic              ce_i,
    input  logic [NOTE_W-1:0] addr_i,
    output logic [STEP_W-1:0] data_o
);
    logic [STEP_W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (ce_i) data_q <= {addr_i, 9'd0} | {9'd0, addr_i};
    end

    assign data_o = data_q;
endmodule

// File: rtl/voice_pipe.sv
// rtl/voice_pipe.sv - per-voice phase accumulators and ROM pipeline
// Optional: PHASE_RESET_ON_GATE_EN zeroes a voice's accumulator on a 0->1 gate change.
module voice_pipe
    import vsynth_voice_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int ACC_W   = 23,
    parameter int PHASE_W = 7,
    parameter int VI_W    = $clog2(VOICES)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      issue_valid_i,
    input  logic [VI_W-1:0]           issue_idx_i,
    input  voice_cfg_t [VOICES-1:0]   cfg_i,
    output logic                      voice_valid_o,
    output logic [VI_W-1:0]           voice_idx_o,
    output logic [PHASE_W-1:0]        voice_phase_o,
    output logic [SAMPLE_W-1:0]       voice_sample_o
);
    logic [ACC_W-1:0]    acc_q [VOICES];
    logic [STEP_W-1:0]   step;
    logic [SAMPLE_W-1:0] rom_data;
    logic                s2_valid_q, s3_valid_q, s3_gate_q;
    logic [VI_W-1:0]     s2_idx_q, s3_idx_q;
    logic [PHASE_W-1:0]  s3_phase_q;
    logic [ACC_W-1:0]    acc_base, acc_new;
    voice_cfg_t          s2_cfg;
`ifdef PHASE_RESET_ON_GATE_EN
    logic [VOICES-1:0]   gate_prev_q;
`endif

    assign s2_cfg = cfg_i[s2_idx_q];

    step_size_rom u_step_rom (
        .clk_i  (clk_i),
        .ce_i   (1'b1),
        .addr_i (cfg_i[issue_idx_i].note),
        .data_o (step)
    );

    always_comb begin
        acc_base = acc_q[s2_idx_q];
`ifdef PHASE_RESET_ON_GATE_EN
        if (s2_cfg.gate && !gate_prev_q[s2_idx_q]) acc_base = '0;
`endif
        acc_new = s2_cfg.gate ? acc_base + ACC_W'(step) : acc_base;
    end

    // Gated-off voices still fetch so the pipeline timing is voice-independent.
    sample_rom #(.PHASE_W(PHASE_W)) u_sample_rom (
        .clk_i  (clk_i),
        .ce_i   (1'b1),
        .a1_i   (s2_cfg.prog),
        .a2_i   (acc_new[ACC_W-1 -: PHASE_W]),
        .data_o (rom_data)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < VOICES; i++) acc_q[i] <= '0;
`ifdef PHASE_RESET_ON_GATE_EN
            gate_prev_q <= '0;
`endif
            s2_valid_q <= 1'b0;
            s2_idx_q   <= '0;
            s3_valid_q <= 1'b0;
            s3_idx_q   <= '0;
            s3_phase_q <= '0;
            s3_gate_q  <= 1'b0;
        end else begin
            s2_valid_q <= issue_valid_i;
            s2_idx_q   <= issue_idx_i;
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                acc_q[s2_idx_q] <= acc_new;
`ifdef PHASE_RESET_ON_GATE_EN
                gate_prev_q[s2_idx_q] <= s2_cfg.gate;
`endif
                s3_idx_q   <= s2_idx_q;
                s3_phase_q <= acc_new[ACC_W-1 -: PHASE_W];
                s3_gate_q  <= s2_cfg.gate;
            end
        end
    end

    assign voice_valid_o  = s3_valid_q;
    assign voice_idx_o    = s3_idx_q;
    assign voice_phase_o  = s3_phase_q;
    assign voice_sample_o = (s3_valid_q && s3_gate_q) ? rom_data : '0;
endmodule

// File: rtl/wavetable_voice_engine.sv
// rtl/wavetable_voice_engine.sv - time-multiplexed N-voice wavetable oscillator with frame mix
// Optional: PHASE_RESET_ON_GATE_EN (handled in voice_pipe).
module wavetable_voice_engine
    import vsynth_voice_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int ACC_W   = 23,
    parameter int PHASE_W = 7,
    parameter int VI_W    = $clog2(VOICES)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     tick_i,
    input  logic                     cfg_we_i,
    input  logic [VI_W-1:0]          cfg_voice_i,
    input  logic [NOTE_W-1:0]        cfg_note_i,
    input  logic [6:0]               cfg_prog_i,
    input  logic                     cfg_gate_i,
    input  logic                     ovr_clr_i,
    output logic                     busy_o,
    output logic                     voice_valid_o,
    output logic [VI_W-1:0]          voice_idx_o,
    output logic [PHASE_W-1:0]       voice_phase_o,
    output logic [SAMPLE_W-1:0]      voice_sample_o,
    output logic [SAMPLE_W+VI_W-1:0] mix_out_o,
    output logic                     mix_valid_o,
    output logic                     overrun_o
);
    localparam int MIX_W = SAMPLE_W + VI_W;

    voice_cfg_t [VOICES-1:0] live_q, live_d, shadow_q;
    state_e                  state_q;
    logic [VI_W-1:0]         v_q;
    logic                    drain_q, overrun_q, accept;
    logic [MIX_W-1:0]        mix_acc_q, mix_out_q, mix_sum;

    assign accept  = (state_q == ST_IDLE) && tick_i;
    assign mix_sum = mix_acc_q + MIX_W'(voice_sample_o);

    // Same-cycle write and tick must reach the snapshot, so shadows load from live_d.
    always_comb begin
        live_d = live_q;
        if (cfg_we_i) live_d[cfg_voice_i] = {cfg_note_i, cfg_prog_i, cfg_gate_i};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            live_q    <= '0;
            shadow_q  <= '0;
            state_q   <= ST_IDLE;
            v_q       <= '0;
            drain_q   <= 1'b0;
            mix_acc_q <= '0;
            mix_out_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            live_q <= live_d;
            if (accept) shadow_q <= live_d;

            if (tick_i && state_q != ST_IDLE) overrun_q <= 1'b1;
            else if (ovr_clr_i)               overrun_q <= 1'b0;

            if (accept)             mix_acc_q <= '0;
            else if (voice_valid_o) mix_acc_q <= mix_sum;

            case (state_q)
                ST_IDLE: begin
                    if (tick_i) begin
                        state_q <= ST_ISSUE;
                        v_q     <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (v_q == VI_W'(VOICES - 1)) begin
                        state_q <= ST_DRAIN;
                        drain_q <= 1'b0;
                    end else begin
                        v_q <= v_q + VI_W'(1);
                    end
                end
                ST_DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q   <= ST_DONE;
                        mix_out_q <= mix_sum;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    voice_pipe #(
        .VOICES  (VOICES),
        .ACC_W   (ACC_W),
        .PHASE_W (PHASE_W),
        .VI_W    (VI_W)
    ) u_voice_pipe (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .issue_valid_i  (state_q == ST_ISSUE),
        .issue_idx_i    (v_q),
        .cfg_i          (shadow_q),
        .voice_valid_o  (voice_valid_o),
        .voice_idx_o    (voice_idx_o),
        .voice_phase_o  (voice_phase_o),
        .voice_sample_o (voice_sample_o)
    );

    assign busy_o      = (state_q != ST_IDLE);
    assign mix_valid_o = (state_q == ST_DONE);
    assign mix_out_o   = mix_out_q;
    assign overrun_o   = overrun_q;
endmodule

// File: tb/tb_wavetable_voice_engine.sv
// tb/tb_wavetable_voice_engine.sv - directed self-checking bench for wavetable_voice_engine (4 voices)
module tb_wavetable_voice_engine;
    localparam int V  = 4;
    localparam int VW = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tick = 1'b0;
    logic         cfg_we = 1'b0;
    logic [VW-1:0] cfg_voice = '0;
    logic [6:0]   cfg_note = '0;
    logic [6:0]   cfg_prog = '0;
    logic         cfg_gate = 1'b0;
    logic         ovr_clr = 1'b0;
    logic         busy, voice_valid, mix_valid, overrun;
    logic [VW-1:0] voice_idx;
    logic [6:0]   voice_phase;
    logic [7:0]   voice_sample;
    logic [9:0]   mix_out;

    int n_chk = 0;
    int n_bad = 0;

    logic [6:0]  note_l [V];
    logic [6:0]  prog_l [V];
    bit          gate_l [V];
    logic [22:0] acc_m  [V];
    bit          gprev  [V];

    always #5 clk = ~clk;

    wavetable_voice_engine #(.VOICES(V), .ACC_W(23), .PHASE_W(7)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .tick_i         (tick),
        .cfg_we_i       (cfg_we),
        .cfg_voice_i    (cfg_voice),
        .cfg_note_i     (cfg_note),
        .cfg_prog_i     (cfg_prog),
        .cfg_gate_i     (cfg_gate),
        .ovr_clr_i      (ovr_clr),
        .busy_o         (busy),
        .voice_valid_o  (voice_valid),
        .voice_idx_o    (voice_idx),
        .voice_phase_o  (voice_phase),
        .voice_sample_o (voice_sample),
        .mix_out_o      (mix_out),
        .mix_valid_o    (mix_valid),
        .overrun_o      (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] step_of(input logic [6:0] n);
        return (16'(n) << 9) | 16'(n);
    endfunction

    function automatic logic [7:0] rom_of(input logic [6:0] prog, input logic [6:0] ph);
        return 8'((int'(ph) * 2 + int'(prog)) & 255);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < V; k++) begin
            note_l[k] = '0; prog_l[k] = '0; gate_l[k] = 0; acc_m[k] = '0; gprev[k] = 0;
        end
    endtask

    task automatic drive_cfg(input int v, input logic [6:0] n, input logic [6:0] p, input bit g);
        cfg_we = 1'b1; cfg_voice = VW'(v); cfg_note = n; cfg_prog = p; cfg_gate = g;
        note_l[v] = n; prog_l[v] = p; gate_l[v] = g;
    endtask

    task automatic cfg_write(input int v, input logic [6:0] n, input logic [6:0] p, input bit g);
        drive_cfg(v, n, p, g);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_vvalid"}, 32'(voice_valid), 0);
        check({tag, "_vidx"}, 32'(voice_idx), 0);
        check({tag, "_vphase"}, 32'(voice_phase), 0);
        check({tag, "_vsample"}, 32'(voice_sample), 0);
        check({tag, "_mix"}, 32'(mix_out), 0);
        check({tag, "_mixvalid"}, 32'(mix_valid), 0);
        check({tag, "_overrun"}, 32'(overrun), 0);
    endtask

    // Runs one frame from tick (cycle T) through T+10; extra events are placed at cycle T+j.
    // cfg_at == 0 writes voice 0 in the tick cycle itself; -1 disables an event.
    task automatic run_frame(input int tick_at, input int clr_at, input int cfg_at,
                             input int rst_at, input logic [6:0] new_note);
        logic [6:0] exp_ph [V];
        logic [7:0] exp_sm [V];
        logic [9:0] exp_mix;
        logic [6:0] note_s [V];
        logic [6:0] prog_s [V];
        bit         gate_s [V];
        logic [22:0] base;
        bit aborted;

        if (cfg_at == 0) drive_cfg(0, new_note, prog_l[0], gate_l[0]);
        tick = 1'b1;
        exp_mix = '0;
        for (int k = 0; k < V; k++) begin
            note_s[k] = note_l[k]; prog_s[k] = prog_l[k]; gate_s[k] = gate_l[k];
            base = acc_m[k];
`ifdef PHASE_RESET_ON_GATE_EN
            if (gate_s[k] && !gprev[k]) base = '0;
            gprev[k] = gate_s[k];
`endif
            acc_m[k] = gate_s[k] ? base + 23'(step_of(note_s[k])) : base;
            exp_ph[k] = acc_m[k][22:16];
            exp_sm[k] = gate_s[k] ? rom_of(prog_s[k], exp_ph[k]) : 8'd0;
            exp_mix = exp_mix + 10'(exp_sm[k]);
        end
        @(negedge clk);
        tick = 1'b0; cfg_we = 1'b0;
        aborted = 0;
        for (int j = 1; j <= 10; j++) begin
            if (!aborted) begin
                check("busy", 32'(busy), 32'(j <= V + 3));
                check("vvalid", 32'(voice_valid), 32'(j >= 3 && j <= V + 2));
                check("mixvalid", 32'(mix_valid), 32'(j == V + 3));
                if (j >= 3 && j <= V + 2) begin
                    check("vidx", 32'(voice_idx), 32'(j - 3));
                    check("vphase", 32'(voice_phase), 32'(exp_ph[j-3]));
                    check("vsample", 32'(voice_sample), 32'(exp_sm[j-3]));
                end
                if (j == V + 3) check("mix", 32'(mix_out), 32'(exp_mix));
            end else begin
                check("abort_busy", 32'(busy), 0);
                check("abort_vvalid", 32'(voice_valid), 0);
                check("abort_mixvalid", 32'(mix_valid), 0);
            end
            tick    = (j == tick_at);
            ovr_clr = (j == clr_at);
            if (j == cfg_at) drive_cfg(0, new_note, prog_l[0], gate_l[0]);
            if (j == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_zero_outputs("rst_mid");
                model_reset();
                aborted = 1;
            end
            @(negedge clk);
            tick = 1'b0; ovr_clr = 1'b0; cfg_we = 1'b0; rst_n = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single voice: note 69 -> step 0x8A45, first phase 0, second phase 1 (sample 2).
        cfg_write(0, 7'd69, 7'd0, 1);
        cfg_write(2, 7'd50, 7'd5, 0);
        run_frame(-1, -1, -1, -1, '0);
        check("f1_acc_hand", 32'(acc_m[0]), 32'h8A45);
        run_frame(-1, -1, -1, -1, '0);

        // Several active voices contributing to the mix.
        cfg_write(1, 7'd100, 7'd9, 1);
        cfg_write(3, 7'd127, 7'd3, 1);
        for (int f = 0; f < 3; f++) run_frame(-1, -1, -1, -1, '0);

        // Overrun: tick in ISSUE, tick in DONE, clear, clear colliding with tick-while-busy.
        run_frame(3, -1, -1, -1, '0);
        check("ovr_set", 32'(overrun), 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("ovr_clr", 32'(overrun), 0);
        run_frame(V + 3, -1, -1, -1, '0);
        check("ovr_done_cycle", 32'(overrun), 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("ovr_clr2", 32'(overrun), 0);
        run_frame(3, 3, -1, -1, '0);
        check("ovr_clr_vs_tick", 32'(overrun), 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;

        // Config written mid-frame applies to the next frame; config with tick applies now.
        run_frame(-1, -1, 2, -1, 7'd40);
        run_frame(-1, -1, -1, -1, '0);
        run_frame(-1, -1, 0, -1, 7'd90);

        // Gate off holds the accumulator; gate back on continues or restarts per build.
        cfg_write(0, 7'd90, 7'd0, 0);
        run_frame(-1, -1, -1, -1, '0);
        cfg_write(0, 7'd90, 7'd0, 1);
        run_frame(-1, -1, -1, -1, '0);

        // Reset mid-frame, then a fresh frame from zeroed accumulators.
        run_frame(-1, -1, -1, 4, '0);
        cfg_write(0, 7'd69, 7'd0, 1);
        run_frame(-1, -1, -1, -1, '0);

        // Long run on note 60: accumulator wraps modulo 2^23 several times.
        cfg_write(0, 7'd60, 7'd0, 1);
        for (int f = 0; f < 1000; f++) run_frame(-1, -1, -1, -1, '0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/wavetable_voice_engine.md
Name: wavetable_voice_engine

Overview:
- Time-multiplexed N-voice wavetable oscillator; successor to the single-voice step_size_rom/sample_rom/phase-counter chain.
- Per-voice phase accumulators advance by the note's step and fetch 8-bit samples per program.
- Produces a per-voice sample stream and a summed mix once per audio frame (tick).
- Sits between the MIDI/voice-allocation logic and the output DAC/PWM stage.

Parameters:
VOICES, 8, number of voices (2..32), processed in index order each frame
ACC_W, 23, phase accumulator width; must be >= 16 and > PHASE_W
PHASE_W, 7, phase index width fed to sample_rom (top PHASE_W bits of accumulator)
VI_W, $clog2(VOICES), voice index width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  frame start pulse (one cycle)
cfg_we  in  1  voice config write strobe
cfg_voice  in  VI_W  voice to configure
cfg_note  in  7  note number (step_size_rom address)
cfg_prog  in  7  program/waveform (sample_rom A1)
cfg_gate  in  1  voice enabled
ovr_clr  in  1  clears overrun flag
busy  out  1  frame in progress
voice_valid  out  1  voice_sample/voice_idx/voice_phase valid
voice_idx  out  VI_W  voice of current sample
voice_phase  out  PHASE_W  phase index used
voice_sample  out  8  sample (0 when gated off)
mix_out  out  8+VI_W  unsigned sum of voice samples for frame
mix_valid  out  1  one-cycle pulse, mix_out updated
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset: all outputs 0; accumulators, config regs (note/prog/gate) 0; FSM IDLE. Reset mid-frame aborts the frame; no mix_valid.
- Config: cfg_we writes live regs in 1 cycle, any state. On accepted tick, live regs snapshot to shadow regs; the frame uses only shadows. Writes during busy take effect next frame.
- FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
  - IDLE: tick accepted; busy=0.
  - ISSUE: voice counter v=0..VOICES-1, one per cycle; step ROM addressed with shadow note[v].
  - DRAIN: 2 cycles flushing the pipeline.
  - DONE: mix_valid=1 one cycle.
- Pipeline per voice, tick at cycle T, voice k issued at T+1+k:
  - T+2+k: acc[k] <= acc[k]+step (mod 2^ACC_W) if gate, else held.
  - T+2+k: sample_rom addressed with (new acc)[ACC_W-1 -: PHASE_W] and prog[k]; gated-off voices still address the ROM.
  - T+3+k: voice_valid=1, voice_sample = ROM data if gate else 0.
- mix accumulator: cleared at tick acceptance; adds voice_sample at each voice_valid; registered to mix_out with mix_valid at T+4+VOICES-1. No overflow possible at width 8+VI_W.
- busy=1 from T+1 through the mix_valid cycle inclusive.
- Tick while busy (including the mix_valid cycle): ignored, overrun<=1. ovr_clr clears overrun; simultaneous tick-while-busy and ovr_clr leaves overrun=1.
- cfg_we and tick in the same cycle: snapshot takes the newly written value.
- Accumulator wrap is silent modulo 2^ACC_W.
- ROM ce tied high internally.

Optional Feature:
PHASE_RESET_ON_GATE_EN:
- Defined: a 0->1 change of a voice's shadow gate between frames zeroes acc[v] before that frame's add, so the first phase = step>>(ACC_W-PHASE_W).
- Undefined: accumulators free-run; gate only enables advance.

Decomposition:
- Package vsynth_voice_pkg holds:
  - typedef voice_cfg_t {note[6:0], prog[6:0], gate}
  - FSM state enum
  - constants SAMPLE_W=8, NOTE_W=7, STEP_W=16
- Sub-module voice_pipe: accumulator array update plus the two ROM instances (step_size_rom, sample_rom). Top keeps FSM, snapshot, mix and overrun.

Test Plan:
- VOICES=4, voice0 note=69 prog=0 gate=1, others gate=0, one tick:
  - voice_valid at T+3..T+6, idx 0..3.
  - voice0 phase = step_size_rom[69]>>16; voices1-3 sample=0.
  - mix_out = voice0 sample; mix_valid at T+7.
- 1000 ticks with note 60: acc0 matches model (n*step mod 2^23); wrap observed, phase sequence matches.
- Tick at T+3 of a frame: frame completes normally, overrun=1; ovr_clr -> 0; ovr_clr with a tick-while-busy in the same cycle -> stays 1.
- cfg_we note change at T+2: current frame uses the old note; next frame uses the new one.
- rst_n low at T+4: all outputs 0 immediately; no mix_valid; next tick yields phase from zeroed acc.
- With PHASE_RESET_ON_GATE_EN: gate 0->1 after accumulator nonzero -> first phase = step>>16; without the macro, continues from the held acc.
